// File: rtl/calc_pkg.sv
// Shared opcode constants, FSM state encoding and the elaboration-time
// helper that sizes the BCD output for the calculator core.
package calc_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIVIDE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    // Smallest digit count d with 10^d > 2^bits - 1.
    function automatic int min_digits(input int bits);
        longint lim;
        longint pw;
        int     d;
        lim = (longint'(1) << bits) - 1;
        pw  = 10;
        d   = 1;
        while (pw <= lim) begin
            pw = pw * 10;
            d  = d + 1;
        end
        return d;
    endfunction

endpackage

// File: rtl/calc_core_seq_if.sv
// Start/busy/done request bus between the board controller and the
// sequential calculator core.
interface calc_core_seq_if #(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [2:0]            op;
    logic [WIDTH-1:0]      a;
    logic [WIDTH-1:0]      b;
    logic                  busy;
    logic                  done;
    logic [2*WIDTH-1:0]    result;
    logic [4*DIGITS-1:0]   bcd;
    logic                  err;

    modport master (
        output start, op, a, b,
        input  busy, done, result, bcd, err
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, bcd, err
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: one add-3/shift step per cycle,
// BITS cycles after the start edge done pulses with bcd valid.
module bin2bcd_seq #(
    parameter int BITS   = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BITS-1:0]     bin,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;

    logic [BITS-1:0]    r_sh;
    logic [BW-1:0]      r_bcd;
    logic [CW-1:0]      r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [BW-1:0]      w_adj;
    logic [BW+BITS-1:0] w_cat;

    function automatic logic [BW-1:0] add3(input logic [BW-1:0] v);
        logic [BW-1:0] res;
        res = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5)
                res[4*i +: 4] = v[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

    always_comb begin
        w_adj = add3(r_bcd);
        w_cat = {w_adj, r_sh} << 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_sh   <= '0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_sh   <= bin;
                r_bcd  <= '0;
                r_cnt  <= '0;
                r_busy <= 1'b1;
            end else if (r_busy) begin
                {r_bcd, r_sh} <= w_cat;
                r_cnt         <= r_cnt + 1'b1;
                if (r_cnt == CW'(BITS - 1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
endmodule

// File: rtl/calc_core_seq.sv
// Sequential calculator: add/sub/mul or restoring divide, then a
// double-dabble pass, reported with a single done pulse.
module calc_core_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int DIGITS = 3
) (
    input logic             clk,
    input logic             rst,
    calc_core_seq_if.slave  bus
);
    localparam int RW  = 2 * WIDTH;
    localparam int BW  = 4 * DIGITS;
    localparam int DCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    if (DIGITS < min_digits(RW)) begin : g_digits_check
        $error("calc_core_seq: DIGITS too small for 2*WIDTH-bit result");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [DCW-1:0]   r_dcnt;
    logic [RW-1:0]    r_res;
    logic             r_err_int;
    logic             r_busy;
    logic             r_done;
    logic [RW-1:0]    r_result;
    logic [BW-1:0]    r_bcd;
    logic             r_err;

    logic             w_op_bad;
    logic             w_div0;
    logic             w_go_div;
    logic [RW-1:0]    w_ax;
    logic [RW-1:0]    w_bx;
    logic [RW-1:0]    w_exec_res;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH:0]   w_quo_ext;
    logic [WIDTH-1:0] w_quo_nxt;
    logic             w_div_last;
    logic             w_conv_start;
    logic [RW-1:0]    w_conv_bin;
    logic             w_conv_busy;
    logic             w_conv_done;
    logic [BW-1:0]    w_conv_bcd;

    always_comb begin
        w_op_bad = (r_op > OP_DIV);
        w_div0   = (r_op == OP_DIV) && (r_b == '0);
        w_go_div = (r_op == OP_DIV) && (r_b != '0);
        w_ax     = {{WIDTH{1'b0}}, r_a};
        w_bx     = {{WIDTH{1'b0}}, r_b};
        w_exec_res = '1;
        case (r_op)
            OP_ADD:  w_exec_res = w_ax + w_bx;
            OP_SUB:  w_exec_res = w_ax - w_bx;
            OP_MUL:  w_exec_res = w_ax * w_bx;
            default: w_exec_res = '1;
        endcase
    end

    // Restoring step: the dividend shifts out of r_quo MSB-first while
    // quotient bits shift in at the bottom.
    always_comb begin
        w_shift    = {r_rem, r_quo[WIDTH-1]};
        w_diff     = w_shift - {1'b0, r_b};
        w_ge       = (w_shift >= {1'b0, r_b});
        w_rem_nxt  = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        w_quo_ext  = {r_quo, w_ge};
        w_quo_nxt  = w_quo_ext[WIDTH-1:0];
        w_div_last = (r_state == ST_DIVIDE) && (r_dcnt == DCW'(WIDTH - 1));
    end

    always_comb begin
        w_conv_start = ((r_state == ST_EXEC) && !w_go_div) || w_div_last;
        w_conv_bin   = (r_state == ST_DIVIDE) ? {w_quo_nxt, w_rem_nxt} : w_exec_res;
    end

    bin2bcd_seq #(
        .BITS   (RW),
        .DIGITS (DIGITS)
    ) u_bcd (
        .clk   (clk),
        .rst   (rst),
        .start (w_conv_start),
        .bin   (w_conv_bin),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_conv_bcd)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_result  <= '0;
            r_bcd     <= '0;
            r_dcnt    <= '0;
            r_err_int <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_op    <= bus.op;
                        r_busy  <= 1'b1;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_err_int <= w_op_bad || w_div0;
                    r_res     <= w_exec_res;
                    if (w_go_div) begin
                        r_rem   <= '0;
                        r_quo   <= r_a;
                        r_dcnt  <= '0;
                        r_state <= ST_DIVIDE;
                    end else begin
                        r_state <= ST_CONVERT;
                    end
                end
                ST_DIVIDE: begin
                    r_rem  <= w_rem_nxt;
                    r_quo  <= w_quo_nxt;
                    r_dcnt <= r_dcnt + 1'b1;
                    if (w_div_last) begin
                        r_res   <= {w_quo_nxt, w_rem_nxt};
                        r_state <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (w_conv_done && !w_conv_busy) begin
                        r_result <= r_res;
                        r_bcd    <= w_conv_bcd;
                        r_err    <= r_err_int;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.bcd    = r_bcd;
    assign bus.err    = r_err;
endmodule

// File: tb/tb_calc_core_seq.sv
// Directed and random checks of calc_core_seq against an arithmetic
// reference model (results, BCD, error flag, latency, handshake).
module tb_calc_core_seq;
    localparam int W = 4;
    localparam int D = 3;
    localparam int M = 1 << (2 * W);

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    calc_core_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

    calc_core_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_res(input int op, input int a, input int b);
        case (op)
            0:       return (a + b) % M;
            1:       return ((a - b) % M + M) % M;
            2:       return (a * b) % M;
            3:       return (b == 0) ? M - 1 : (a / b) * (1 << W) + (a % b);
            default: return M - 1;
        endcase
    endfunction

    function automatic int model_err(input int op, input int b);
        return (op > 3 || (op == 3 && b == 0)) ? 1 : 0;
    endfunction

    function automatic int model_bcd(input int v);
        int r = 0;
        int x = v;
        for (int i = 0; i < D; i++) begin
            r += (x % 10) << (4 * i);
            x /= 10;
        end
        return r;
    endfunction

    function automatic int model_lat(input int op, input int b);
        return (op == 3 && b != 0) ? 3 * W + 2 : 2 * W + 2;
    endfunction

    // One operation; optionally a second start with other operands mid-flight.
    task automatic run_op(input string tag, input int op, input int a, input int b, input bit inject);
        int n = 0;
        int gaps = 0;
        int extra = 0;
        bit got = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 3'(op);
        bus.a = W'(a);
        bus.b = W'(b);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op = 3'($urandom);
        bus.a = W'($urandom);
        bus.b = W'($urandom);
        while (!got && n < 60) begin
            @(negedge clk);
            n++;
            if (inject && n == 5) begin
                bus.start = 1'b1;
                bus.op = 3'((op + 2) % 4);
                bus.a = W'(a ^ 5);
                bus.b = W'(b ^ 3);
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) got = 1;
            else if (bus.busy !== 1'b1) gaps++;
        end
        bus.start = 1'b0;
        check({tag, ".latency"}, 64'(n), 64'(model_lat(op, b)));
        check({tag, ".result"}, 64'(bus.result), 64'(model_res(op, a, b)));
        check({tag, ".bcd"}, 64'(bus.bcd), 64'(model_bcd(model_res(op, a, b))));
        check({tag, ".err"}, 64'(bus.err), 64'(model_err(op, b)));
        check({tag, ".busy_at_done"}, 64'(bus.busy), 64'(1));
        check({tag, ".busy_gaps"}, 64'(gaps), 64'(0));
        @(negedge clk);
        check({tag, ".done_width"}, 64'(bus.done), 64'(0));
        check({tag, ".busy_after"}, 64'(bus.busy), 64'(0));
        if (inject) begin
            for (int i = 0; i < 15; i++) begin
                @(negedge clk);
                if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
            end
            check({tag, ".no_extra_op"}, 64'(extra), 64'(0));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int dn;
        bus.start = 1'b0;
        bus.op = '0;
        bus.a = '0;
        bus.b = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset.busy", 64'(bus.busy), 64'(0));
        check("reset.done", 64'(bus.done), 64'(0));
        check("reset.result", 64'(bus.result), 64'(0));
        check("reset.bcd", 64'(bus.bcd), 64'(0));
        check("reset.err", 64'(bus.err), 64'(0));

        run_op("add_9_7", 0, 9, 7, 0);
        run_op("sub_3_5", 1, 3, 5, 0);
        run_op("mul_15_15", 2, 15, 15, 0);
        run_op("div_13_4", 3, 13, 4, 0);
        run_op("div_7_0", 3, 7, 0, 0);
        run_op("op_101", 5, 6, 2, 0);
        run_op("inject_add", 0, 12, 11, 1);

        // Reset in the middle of a divide aborts it.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd3; bus.a = 4'd13; bus.b = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_div.busy", 64'(bus.busy), 64'(0));
        check("rst_div.done", 64'(bus.done), 64'(0));
        check("rst_div.result", 64'(bus.result), 64'(0));
        check("rst_div.bcd", 64'(bus.bcd), 64'(0));
        dn = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) dn++;
        end
        check("rst_div.no_done", 64'(dn), 64'(0));
        run_op("add_after_rst", 0, 4, 5, 0);

        // Start held high: the next op is accepted one edge after DONE ends.
        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd0; bus.a = 4'd1; bus.b = 4'd2;
        n = 0;
        while (bus.done !== 1'b1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("held.first_result", 64'(bus.result), 64'(3));
        bus.a = 4'd5; bus.b = 4'd6;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.done !== 1'b1 && n < 60);
        bus.start = 1'b0;
        check("held.gap", 64'(n), 64'(12));
        check("held.second_result", 64'(bus.result), 64'(11));
        repeat (15) @(negedge clk);

        for (int k = 0; k < 30; k++) begin
            int op;
            int a;
            int b;
            op = $urandom_range(0, 7);
            a = $urandom_range(0, (1 << W) - 1);
            b = (k % 7 == 0) ? 0 : $urandom_range(0, (1 << W) - 1);
            run_op($sformatf("rand%0d_op%0d_%0d_%0d", k, op, a, b), op, a, b, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/calc_core_seq.md
# calc_core_seq

Parametrised sequential calculator core for the board-level calculator: captures two WIDTH-bit operands and an opcode on a start handshake, performs add/sub/mul/divide (iterative restoring divider), then converts the 2·WIDTH-bit result to packed BCD with an iterative double-dabble converter. It replaces the per-operation combinational datapath plus chained dividers with one start/busy/done engine. The 7-segment driver and LED outputs consume `result`, `bcd` and `err`.

## Interface
- `WIDTH`, default 4: operand width; result width is 2·WIDTH.
- `DIGITS`, default 3: BCD digits on `bcd`; must satisfy 10^DIGITS > 2^(2·WIDTH)−1 (checked at elaboration).
- `clk`  in  1: single clock; all logic on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only in IDLE.
- `op`  in  3: opcode, sampled at accept.
- `a`, `b`  in  WIDTH each: operands, sampled at accept.
- `busy`  out  1: high from the accept edge until the edge that leaves DONE.
- `done`  out  1: one-cycle pulse; `result`/`bcd`/`err` valid.
- `result`  out  2·WIDTH: binary result.
- `bcd`  out  4·DIGITS: packed BCD of `result`, digit 0 in [3:0].
- `err`  out  1: divide-by-zero or invalid opcode.

## Operation
- Opcodes: 000 ADD a+b; 001 SUB (a−b) mod 2^(2·WIDTH), operands zero-extended; 010 MUL a·b; 011 DIV result = {quotient, remainder}, each WIDTH bits; 100–111 invalid.
- Invalid opcode or DIV with b=0: result = all ones, err=1; BCD conversion still runs (W=4 → bcd 0x255).
- FSM states: IDLE, EXEC, DIVIDE, CONVERT, DONE.
  - IDLE: start=1 → capture a,b,op; → EXEC.
  - EXEC: ADD/SUB/MUL/invalid/div-by-zero → load result, → CONVERT; DIV with b≠0 → DIVIDE.
  - DIVIDE: one restoring step per cycle, WIDTH cycles; last step loads {q,r} into result, → CONVERT.
  - CONVERT: double-dabble, one shift (with add-3 on digits ≥5) per cycle, 2·WIDTH cycles; → DONE.
  - DONE: done=1 one cycle; → IDLE.
- `result`, `bcd`, `err` update only when entering DONE; they hold until the next DONE or reset.
- start while busy is ignored (not queued); start held high in IDLE after DONE begins a new operation.
- Operand/op inputs are don't-care except at the accept edge.

## Timing
- Accept edge = edge 0 (start=1 in IDLE). Non-DIV: done high in the cycle after edge 2·WIDTH+2 (W=4: done visible 10 cycles after accept). DIV, b≠0: 3·WIDTH+2 (W=4: 14).
- busy rises in the cycle after the accept edge; falls together with done.
- Earliest next accept: the edge ending the DONE cycle is not an accept; first accept is the following edge.
- Reset: at the edge where rst=1, state ← IDLE; busy, done, err ← 0; result, bcd ← 0. Reset mid-DIVIDE/CONVERT aborts; no done is produced. rst and start together: reset wins.

## Structure
- Package `calc_pkg`: opcode constants (OP_ADD…OP_DIV), FSM state encoding, helper function for the minimum DIGITS check.
- Sub-module `bin2bcd_seq` (parameters BITS, DIGITS; ports clk, rst, start, bin, busy, done, bcd): double-dabble converter. The divider stays inline in the FSM.

## Test plan
- W=4: a=9, b=7, ADD → result 0x10, bcd 0x016, err 0, done 10 cycles after accept, exactly one cycle wide.
- a=3, b=5, SUB → result 0xFE, bcd 0x254; a=15, b=15, MUL → result 0xE1, bcd 0x225.
- a=13, b=4, DIV → result 0x31, bcd 0x049, done 14 cycles after accept.
- a=7, b=0, DIV → result 0xFF, err 1, bcd 0x255, done after 10 cycles; op=101 → same response.
- start pulsed during CONVERT with different operands → ignored, first result unchanged, busy stays high, exactly one done.
- rst for one cycle mid-DIVIDE → next cycle busy 0, result 0, bcd 0, no done; new ADD afterwards completes normally.
